fir_decim_sat: RTL and testbench

FIR_DECIM_SAT -- requirements
Module: fir_decim_sat

---
 rtl/fir_decim_sat.sv | 109 ++++++++++
 tb/tb_fir_decim_sat.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_sat.sv
// fir_decim_sat: keep 1 of N FIR sums, round/shift/saturate, buffer in a FWFT FIFO.
// Optional round-half-up scaling via FIR_DECIM_ROUND_EN (truncation when undefined).
module fir_decim_sat #(
  parameter real TCQ        = 0.1,
  parameter int  DIN_WIDTH  = 48,
  parameter int  DOUT_WIDTH = 16,
  parameter int  FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic [7:0]            decim_num_i,
  input  logic [5:0]            shift_i,
  input  logic [DIN_WIDTH-1:0]  s_axis_tdata_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  output logic [DOUT_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic [15:0]           drop_cnt_o,
  output logic                  ovf_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH != (1 << AW) || TCQ < 0.0) begin : g_bad_param
    $error("fir_decim_sat: FIFO_DEPTH must be a power of 2 and TCQ non-negative");
  end

  logic                  r_ready, r_s1_v, r_s2_v, r_ovf;
  logic [7:0]            r_phase;
  logic [DIN_WIDTH:0]    r_s1;
  logic [DOUT_WIDTH-1:0] r_s2;
  logic [AW:0]           r_wptr, r_rptr;
  logic [15:0]           r_drop;
  logic [DOUT_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic                  w_acc, w_ph0, w_keep, w_sat, w_empty, w_full, w_rd, w_wr, w_drop;
  logic [7:0]            w_cur, w_phase_nxt;
  logic [DIN_WIDTH:0]    w_round, w_sum, w_sh;

  // A phase left above decim_num_i by a mid-stream change restarts at 0.
  assign w_acc       = s_axis_tvalid_i & r_ready;
  assign w_ph0       = (r_phase == 8'd0) || (r_phase > decim_num_i);
  assign w_cur       = w_ph0 ? 8'd0 : r_phase;
  assign w_phase_nxt = (w_cur >= decim_num_i) ? 8'd0 : w_cur + 8'd1;
  assign w_keep      = w_acc & w_ph0;

`ifdef FIR_DECIM_ROUND_EN
  assign w_round = (shift_i != 6'd0) ? ({{DIN_WIDTH{1'b0}}, 1'b1} << (shift_i - 6'd1)) : '0;
`else
  assign w_round = '0;
`endif
  assign w_sum = {1'b0, s_axis_tdata_i} + w_round;
  assign w_sh  = r_s1 >> shift_i;
  assign w_sat = |w_sh[DIN_WIDTH:DOUT_WIDTH];

  // Extra pointer bit distinguishes full from empty.
  assign w_empty = r_wptr == r_rptr;
  assign w_full  = (r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}};
  assign w_rd    = !w_empty & m_axis_tready_i;
  assign w_wr    = r_s2_v & (!w_full | w_rd);
  assign w_drop  = r_s2_v & w_full & !w_rd;

  assign s_axis_tready_o = r_ready;
  assign m_axis_tvalid_o = !w_empty;
  assign m_axis_tdata_o  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign drop_cnt_o      = r_drop;
  assign ovf_o           = r_ovf;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ready <= 1'b0;
      r_phase <= '0;
      r_s1_v  <= 1'b0;
      r_s2_v  <= 1'b0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (clr_i) begin
        r_phase <= '0;
        r_s1_v  <= 1'b0;
        r_s2_v  <= 1'b0;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_drop  <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_acc) r_phase <= w_phase_nxt;
        r_s1_v <= w_keep;
        r_s2_v <= r_s1_v;
        if (w_keep) r_s1 <= w_sum;
        if (r_s1_v) r_s2 <= w_sat ? '1 : w_sh[DOUT_WIDTH-1:0];
        if (r_s1_v && w_sat) r_ovf <= 1'b1;
        if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
        if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_s2;
  end
endmodule

// File: tb/tb_fir_decim_sat.sv
// tb_fir_decim_sat: table-driven scaling vectors plus decimation, FIFO-full and reset sequences.
module tb_fir_decim_sat;
  logic        clk = 0, rst_n = 0, clr = 0;
  logic [7:0]  decim = 0;
  logic [5:0]  shift = 0;
  logic [47:0] s_tdata = 0;
  logic        s_tvalid = 0, s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tready = 1;
  logic [15:0] drop_cnt;
  logic        ovf;

  int n_chk = 0, n_fail = 0;
  logic [15:0] got[$];
  int first_cyc;

  fir_decim_sat dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .decim_num_i(decim), .shift_i(shift),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
    .drop_cnt_o(drop_cnt), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  sh;
    logic [47:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_and_get(input logic [47:0] d, output logic [15:0] q, output int lat);
    s_tdata = d;
    s_tvalid = 1;
    tick();
    s_tvalid = 0;
    lat = 1;
    while (!m_tvalid && lat < 20) begin
      tick();
      lat++;
    end
    q = m_tdata;
  endtask

  task automatic run_stream(input int nb, input logic [47:0] base, input int tail);
    got.delete();
    first_cyc = -1;
    for (int i = 0; i < nb + tail; i++) begin
      s_tvalid = (i < nb);
      s_tdata = base + 48'(i);
      tick();
      if (m_tvalid) begin
        got.push_back(m_tdata);
        if (first_cyc < 0) first_cyc = i + 1;
      end
    end
    s_tvalid = 0;
  endtask

  task automatic fill(input int nb, input logic [47:0] base);
    for (int i = 0; i < nb; i++) begin
      s_tvalid = 1;
      s_tdata = base + 48'(i);
      tick();
    end
    s_tvalid = 0;
    repeat (4) tick();
  endtask

  initial begin
    logic [15:0] q;
    int lat;
`ifdef FIR_DECIM_ROUND_EN
    tbl[0] = '{6'd0,  48'h1234,        16'h1234};
    tbl[1] = '{6'd4,  48'h18,          16'h0002};
    tbl[2] = '{6'd8,  48'h12345,       16'h0123};
    tbl[3] = '{6'd8,  48'h123C0,       16'h0124};
    tbl[4] = '{6'd32, 48'h1234_8000_0000, 16'h1235};
    tbl[5] = '{6'd1,  48'h3,           16'h0002};
    tbl[6] = '{6'd0,  48'hFFFF,        16'hFFFF};
`else
    tbl[0] = '{6'd0,  48'h1234,        16'h1234};
    tbl[1] = '{6'd4,  48'h18,          16'h0001};
    tbl[2] = '{6'd8,  48'h12345,       16'h0123};
    tbl[3] = '{6'd8,  48'h123C0,       16'h0123};
    tbl[4] = '{6'd32, 48'h1234_8000_0000, 16'h1234};
    tbl[5] = '{6'd1,  48'h3,           16'h0001};
    tbl[6] = '{6'd0,  48'hFFFF,        16'hFFFF};
`endif
    #12;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #1 rst_n = 1;
    #1 chk("tready_before_edge", s_tready, 0);
    tick();
    chk("tready_after_edge", s_tready, 1);

    // scaling / rounding table
    for (int i = 0; i < 7; i++) begin
      shift = tbl[i].sh;
      beat_and_get(tbl[i].d, q, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 3);
      chk($sformatf("vec%0d_data", i), q, tbl[i].exp);
    end
    chk("no_ovf_after_table", ovf, 0);

    // saturation, sticky until clear
    shift = 0;
    beat_and_get(48'h1_0000, q, lat);
    chk("sat_data", q, 16'hFFFF);
    chk("sat_ovf", ovf, 1);
    beat_and_get(48'h5, q, lat);
    chk("post_sat_data", q, 5);
    chk("ovf_sticky", ovf, 1);
    clr = 1;
    tick();
    clr = 0;
    chk("ovf_cleared", ovf, 0);

    // decimation by 4
    decim = 3;
    run_stream(12, 48'd1, 6);
    chk("decim_count", 64'(got.size()), 3);
    for (int k = 0; k < 3 && k < got.size(); k++)
      chk($sformatf("decim_out%0d", k), got[k], 16'(1 + 4 * k));
    chk("decim_first_cycle", 64'(first_cyc), 3);

    // full FIFO with drops
    decim = 0;
    m_tready = 0;
    fill(20, 48'd100);
    chk("full_drop_cnt", drop_cnt, 4);
    chk("full_tvalid", m_tvalid, 1);
    chk("full_head", m_tdata, 100);
    repeat (3) tick();
    chk("full_head_held", m_tdata, 100);
    m_tready = 1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_valid", k), m_tvalid, 1);
      chk($sformatf("drain%0d_data", k), m_tdata, 16'(100 + k));
      tick();
    end
    chk("drained_empty", m_tvalid, 0);

    // full FIFO, read coincident with stage-2 write
    clr = 1;
    tick();
    clr = 0;
    m_tready = 0;
    fill(16, 48'd200);
    chk("fr_drop_before", drop_cnt, 0);
    s_tvalid = 1;
    s_tdata = 48'd300;
    tick();
    s_tvalid = 0;
    tick();
    m_tready = 1;
    tick();
    m_tready = 0;
    repeat (2) tick();
    chk("fr_drop_after", drop_cnt, 0);
    m_tready = 1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fr%0d_data", k), m_tdata, (k == 15) ? 16'd300 : 16'(201 + k));
      tick();
    end
    chk("fr_empty", m_tvalid, 0);

    // async reset mid-burst, leaving phase non-zero beforehand
    decim = 2;
    m_tready = 0;
    fill(4, 48'd50);
    chk("pre_rst_valid", m_tvalid, 1);
    #3 rst_n = 0;
    #1;
    chk("async_rst_tvalid", m_tvalid, 0);
    chk("async_rst_tready", s_tready, 0);
    chk("async_rst_tdata", m_tdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1 chk("rel_tready_low", s_tready, 0);
    tick();
    chk("rel_tready_high", s_tready, 1);
    chk("rel_empty", m_tvalid, 0);
    decim = 1;
    m_tready = 1;
    run_stream(4, 48'd11, 6);
    chk("rst_decim_count", 64'(got.size()), 2);
    for (int k = 0; k < 2 && k < got.size(); k++)
      chk($sformatf("rst_decim_out%0d", k), got[k], 16'(11 + 2 * k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
